// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encoding and default data width for the FIFO read path.
package fifo_pkg;
    localparam int P_DATA_DEF = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_WAIT} state_t;
endpackage

// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if: FIFO read-side and UART TX handshake bundle for the drain.
interface fifo_rd_drain_if
    import fifo_pkg::*;
#(
    parameter int P_DATA = P_DATA_DEF,
    parameter int P_CNT  = 8
);
    logic              en;
    logic              r_empty;
    logic [P_DATA-1:0] rd_data;
    logic              tx_busy;
    logic              r_inc;
    logic [P_DATA-1:0] tx_data;
    logic              tx_valid;
    logic [P_CNT-1:0]  sent_cnt;
    logic              active;
    modport master (input en, r_empty, rd_data, tx_busy, output r_inc, tx_data, tx_valid, sent_cnt, active);
    modport slave (output en, r_empty, rd_data, tx_busy, input r_inc, tx_data, tx_valid, sent_cnt, active);
endinterface

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: pops one FIFO word at a time and hands it to the UART TX.
// IDLE->LOAD->SEND->WAIT->IDLE keeps pops 4 cycles apart, covering the 2-edge empty-flag latency.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int P_DATA = P_DATA_DEF,
    parameter int P_CNT  = 8
) (
    input  logic             r_clk,
    input  logic             rrst,
    fifo_rd_drain_if.master  bus
);
    state_t            state_q, state_d;
    logic [P_DATA-1:0] tx_data_q, tx_data_d;
    logic [P_CNT-1:0]  sent_cnt_q, sent_cnt_d;

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        sent_cnt_d = sent_cnt_q;
        case (state_q)
            ST_IDLE: state_d = (bus.en && !bus.r_empty) ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
                tx_data_d = bus.rd_data;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                sent_cnt_d = bus.tx_busy ? sent_cnt_q + 1'b1 : sent_cnt_q;
                state_d    = bus.tx_busy ? ST_WAIT : ST_SEND;
            end
            ST_WAIT: state_d = bus.tx_busy ? ST_WAIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge r_clk) begin
        if (rrst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            sent_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            sent_cnt_q <= sent_cnt_d;
        end
    end

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign bus.r_inc    = (state_q == ST_LOAD);
    assign bus.tx_valid = (state_q == ST_SEND);
    assign bus.active   = (state_q != ST_IDLE);
    assign bus.tx_data  = tx_data_q;
    assign bus.sent_cnt = sent_cnt_q;
endmodule

// File: doc/fifo_rd_drain.md
Name: fifo_rd_drain

Overview:
- Read-domain consumer of the async FIFO read side. Pops one word at a time from the FIFO and hands it to the UART transmitter over a valid/busy handshake.
- Sits between the FIFO read controller / memory read port and the UART TX.
- Runs entirely on the read clock.
- Respects the FIFO's two-cycle pointer-to-empty-flag latency, so it never double-pops or reads stale data.

Parameters:
- P_DATA, 8, data word width in bits.
- P_CNT, 8, width of the transmitted-word counter.

Ports:
- r_clk  input  1  read-domain clock; all logic on rising edge.
- rrst  input  1  synchronous active-high reset, sampled on r_clk.
- en  input  1  drain enable (low-power gating); 0 = no new pop starts.
- r_empty  input  1  FIFO empty flag from read controller.
- rd_data  input  P_DATA  FIFO memory read data at current read address (combinational read).
- tx_busy  input  1  UART TX busy; high while a frame is being shifted.
- r_inc  output  1  one-cycle pop strobe to FIFO read controller.
- tx_data  output  P_DATA  word presented to UART TX.
- tx_valid  output  1  tx_data valid; held until accepted.
- sent_cnt  output  P_CNT  count of words accepted by TX; wraps modulo 2^P_CNT.
- active  output  1  high whenever state != IDLE.

Behaviour:
Reset:
- rrst=1 at a rising edge forces state=IDLE.
- r_inc=0, tx_valid=0, tx_data=0, sent_cnt=0, active=0.
- Reset mid-operation abandons the held word; the FIFO is not re-popped.

State machine (one-hot or binary, 4 states):
- IDLE: if en && !r_empty -> LOAD; else stay.
- LOAD (1 cycle):
  - r_inc=1 for exactly this cycle.
  - tx_data <= rd_data captured at this edge.
  - -> SEND.
- SEND:
  - tx_valid=1, tx_data stable.
  - When tx_busy==1 is sampled: tx_valid<=0, sent_cnt<=sent_cnt+1, -> WAIT.
  - Else stay; no timeout.
- WAIT: stay while tx_busy==1; when tx_busy==0 -> IDLE.

Timing and handshake rules:
- Acceptance is defined as tx_busy sampled high while tx_valid=1.
- tx_valid deasserts on the edge after acceptance.
- Minimum LOAD-to-next-LOAD spacing is 4 cycles (LOAD, SEND, WAIT, IDLE).
  - This exceeds the FIFO's r_inc -> pointer -> gray/empty latency of 2 edges.
  - Therefore r_empty in IDLE always reflects the completed pop.
  - Do not shorten this path.
- en deasserting only blocks IDLE->LOAD; a word already in LOAD/SEND/WAIT completes.
- r_empty changes outside IDLE are ignored.
- tx_busy already high on entry to SEND counts as immediate acceptance (same rule).
- r_inc is never asserted when r_empty=1 at the IDLE decision cycle.
- r_inc is never asserted for two consecutive cycles.
- sent_cnt wraps from 2^P_CNT-1 to 0 with no flag.
- tx_data holds its last value after acceptance; it is not cleared.
- Outputs r_inc, tx_valid, active are registered or derived from the state register only, with no combinational path from inputs.

Decomposition:
- Shared package (fifo_pkg):
  - state encoding constants ST_IDLE / ST_LOAD / ST_SEND / ST_WAIT.
  - default data width constant shared with FIFO memory and UART TX.
- Single module; no sub-module needed. The counter is inline.

Test Plan:
1. Reset: hold rrst=1 for 3 cycles with r_empty=0, en=1 -> r_inc=0, tx_valid=0, sent_cnt=0, tx_data=0 throughout.
2. Single word: FIFO holds 0xA5; TX model raises busy 1 cycle after valid and holds it 10 cycles.
   - Required: r_inc pulses exactly once.
   - Required: tx_valid rises the cycle after r_inc with tx_data=0xA5.
   - Required: tx_valid falls the cycle after busy is sampled; sent_cnt=1; returns to IDLE once busy=0.
3. Burst of 8 (0x01..0x08) from a FIFO with 2-cycle empty latency:
   - Required: exactly 8 r_inc pulses, each ≥4 cycles apart.
   - Required: TX receives 0x01..0x08 in order; sent_cnt=8; no pop after empty.
4. en toggling: deassert en during SEND of 0x11 -> 0x11 still completes; no further r_inc while en=0; resumes on next word when en=1.
5. Busy pre-high / stalled: tx_busy stuck high before SEND -> immediate acceptance, stays in WAIT until busy drops. tx_busy stuck low -> tx_valid held indefinitely with stable tx_data.
6. Mid-operation reset in SEND with 0x3C pending, plus counter wrap: P_CNT=2, send 5 words -> sent_cnt sequence 1,2,3,0,1. A reset pulse in SEND clears tx_valid next edge and issues no extra r_inc.
